spi_tx: RTL
===========

# spi_tx

SPI master transmitter: the initiating end of the team's SPI link. It takes a parallel word from the host logic and generates SS, SCK and MOSI from the system clock in any of the four CKP/CPH modes. It also optionally captures MISO, and drives the receiver block across the serial link.

## Interface
- N_BITS, 16: bits per transfer, MSB first; ≥2.
- CLK_DIV, 4: CLK cycles per SCK period; even, ≥2. H = CLK_DIV/2 is the half-period.
- CLK  input  1  system clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  request a transfer; sampled only in IDLE.
- CKP  input  1  clock polarity: idle level of SCK.
- CPH  input  1  clock phase: 0 = sample on leading edge, 1 = sample on trailing edge.
- DATA_IN  input  N_BITS  word to transmit; latched when START is accepted.
- MISO  input  1  serial data from the receiver.
- SCK  output  1  serial clock.
- SS  output  1  slave select, active-low.
- MOSI  output  1  serial data to the receiver.
- DATA_OUT  output  N_BITS  word captured from MISO.
- BUSY  output  1  transfer in progress.
- DONE  output  1  one-cycle pulse when a transfer ends.

## Operation
- All outputs are registered. Reset values: SS=1, SCK=0, MOSI=0, BUSY=0, DONE=0, DATA_OUT=0, state IDLE.
- In IDLE, SCK follows the latched CKP. The latch is loaded from the CKP input every IDLE cycle.
- The leading edge is the SCK transition away from CKP. The trailing edge is the return to CKP.
- The FSM has four states: IDLE, LEAD, SHIFT and TAIL.
  - IDLE → LEAD when START=1. On that edge: SS←0, BUSY←1, latch DATA_IN, latch CKP/CPH, reset the half-period and edge counters.
  - In LEAD, if CPH=0, MOSI←DATA_IN[N_BITS-1] on the same edge that SS falls. If CPH=1, MOSI is held at 0.
  - LEAD → SHIFT after H cycles, on the edge that makes the first SCK leading edge.
  - In SHIFT, SCK toggles every H cycles, for 2·N_BITS edges total.
  - With CPH=0: sample MISO on each leading edge. Advance MOSI to the next bit on each trailing edge except the last.
  - With CPH=1: advance MOSI on each leading edge, starting with the MSB. Sample MISO on each trailing edge.
  - SHIFT → TAIL on the edge producing the 2·N_BITS-th SCK edge. SCK is then at CKP.
  - TAIL → IDLE after H cycles. On that edge: SS←1, MOSI←0, BUSY←0, DONE←1, and the sampled word goes to DATA_OUT.
- MISO bits shift in MSB first.
- START is ignored while BUSY=1. CKP, CPH and DATA_IN changes during a transfer have no effect.
- START held high continuously gives back-to-back transfers separated by exactly one IDLE cycle (SS high for one cycle).
- If RESET is asserted mid-transfer, all outputs go to their reset values immediately. No DONE pulse is produced. DATA_OUT keeps reset value 0.
- The counters wrap only at their defined terminal counts. The edge counter is ⌈log2(2·N_BITS+1)⌉ bits wide.

## Timing
- The START acceptance edge is cycle 0, so SS is low from cycle 1.
- The first SCK leading edge is at cycle H.
- SCK edge k (k=1..2·N_BITS) is at cycle k·H.
- SS rises and DONE pulses at cycle (2·N_BITS+1)·H. With the defaults this is cycle 66.
- The earliest next accepted START is at cycle (2·N_BITS+1)·H+1.
- MOSI is stable for at least H cycles before every sampling edge, and for H cycles after it.

## Configuration
- SPI_TX_MISO_CAPTURE_EN defined: the MISO sampling shift register is present, and DATA_OUT updates on DONE as described above.
- SPI_TX_MISO_CAPTURE_EN undefined: there is no capture logic, and DATA_OUT is constant 0. MISO is unused. All other behaviour is identical.

## Test plan
- Mode 0 (CKP=0, CPH=0), DATA_IN=16'hA5C3, MISO looped to MOSI, START for one cycle → bits sampled on SCK rising edges are A5C3 MSB first. SS low from cycle 1 to 66. DONE at cycle 66. DATA_OUT=16'hA5C3.
- Mode 3 (CKP=1, CPH=1), DATA_IN=16'h3C01, loopback → SCK idles high and 16 falling edges drive MOSI. The rising edges sample 3C01. DATA_OUT=16'h3C01.
- Modes 1 and 2 with MISO tied to 1 → DATA_OUT=16'hFFFF. SCK idle level equals CKP before and after the transfer.
- START pulsed at cycle 10 during a transfer, DATA_IN changed to 16'h0000 → the transfer is unaffected. There is exactly one DONE. No second transfer starts.
- RESET low at cycle 20 of a transfer → within the same cycle SS=1, SCK=0, MOSI=0, BUSY=0. DONE is never asserted. A later START gives a full normal transfer.
- Build without SPI_TX_MISO_CAPTURE_EN, mode 0 loopback with 16'hA5C3 → MOSI and SCK behaviour are identical to the first scenario, and DATA_OUT stays 0.

Source files
------------

// File: rtl/spi_tx.sv
// rtl/spi_tx.sv - SPI master transmitter, all four CKP/CPH modes, optional MISO capture
//
// Purpose: serialises DATA_IN MSB first onto MOSI under SS/SCK and, when
//          SPI_TX_MISO_CAPTURE_EN is defined, shifts MISO into DATA_OUT.
//          Without SPI_TX_MISO_CAPTURE_EN, DATA_OUT is constant 0 and MISO is unused.
// Ports:
//   CLK       system clock, all state updates on posedge
//   RESET     asynchronous active-low reset
//   START     transfer request, sampled only while idle
//   CKP/CPH   clock polarity / phase, latched at START
//   DATA_IN   word to send, latched at START
//   MISO      serial data from the receiver
//   SCK/SS/MOSI  serial link outputs (SS active-low)
//   DATA_OUT  captured word, updated with DONE
//   BUSY      transfer in progress
//   DONE      one-cycle pulse at the end of a transfer
module spi_tx #(
   parameter int N_BITS  = 16,
   parameter int CLK_DIV = 4
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              START,
   input  logic              CKP,
   input  logic              CPH,
   input  logic [N_BITS-1:0] DATA_IN,
   input  logic              MISO,
   output logic              SCK,
   output logic              SS,
   output logic              MOSI,
   output logic [N_BITS-1:0] DATA_OUT,
   output logic              BUSY,
   output logic              DONE
);

   localparam int H  = CLK_DIV / 2;
   localparam int HW = (H > 1) ? $clog2(H) : 1;
   localparam int EW = $clog2(2 * N_BITS + 1);
   localparam logic [HW-1:0] H_LAST = HW'(H - 1);
   localparam logic [EW-1:0] E_LAST = EW'(2 * N_BITS - 1);

   typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TAIL} state_t;

   state_t            state, state_d;
   logic              sck_d, ss_d, mosi_d, busy_d, done_d;
   logic [HW-1:0]     hcnt, hcnt_d;
   logic [EW-1:0]     ecnt, ecnt_d;
   logic [N_BITS-1:0] tx_sh, tx_d;
   logic              cph_q, cph_d;
   logic              tick, leading, sample;
`ifdef SPI_TX_MISO_CAPTURE_EN
   logic [N_BITS-1:0] rx_sh, rx_d;
   logic [N_BITS-1:0] dout_q, dout_d;
`endif

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state <= IDLE;
         SCK   <= 1'b0;
         SS    <= 1'b1;
         MOSI  <= 1'b0;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
         hcnt  <= '0;
         ecnt  <= '0;
         tx_sh <= '0;
         cph_q <= 1'b0;
`ifdef SPI_TX_MISO_CAPTURE_EN
         rx_sh  <= '0;
         dout_q <= '0;
`endif
      end else begin
         state <= state_d;
         SCK   <= sck_d;
         SS    <= ss_d;
         MOSI  <= mosi_d;
         BUSY  <= busy_d;
         DONE  <= done_d;
         hcnt  <= hcnt_d;
         ecnt  <= ecnt_d;
         tx_sh <= tx_d;
         cph_q <= cph_d;
`ifdef SPI_TX_MISO_CAPTURE_EN
         rx_sh  <= rx_d;
         dout_q <= dout_d;
`endif
      end
   end

   // tick marks the end of a half-period; leading is true when the edge
   // about to be produced is the odd-numbered one (away from the idle level).
   assign tick    = (hcnt == H_LAST);
   assign leading = ~ecnt[0];
   // CPH=0 samples on leading edges, CPH=1 on trailing edges.
   assign sample  = leading ^ cph_q;

   always_comb begin
      state_d = state;
      sck_d   = SCK;
      ss_d    = SS;
      mosi_d  = MOSI;
      busy_d  = BUSY;
      done_d  = 1'b0;
      hcnt_d  = hcnt;
      ecnt_d  = ecnt;
      tx_d    = tx_sh;
      cph_d   = cph_q;
`ifdef SPI_TX_MISO_CAPTURE_EN
      rx_d    = rx_sh;
      dout_d  = dout_q;
`endif
      case (state)
         IDLE: begin
            // The SCK register doubles as the CKP latch while idle.
            sck_d = CKP;
            if (START) begin
               state_d = LEAD;
               ss_d    = 1'b0;
               busy_d  = 1'b1;
               cph_d   = CPH;
               hcnt_d  = '0;
               ecnt_d  = '0;
               // CPH=0 presents the MSB now, so the shifter starts one bit on.
               tx_d    = CPH ? DATA_IN : (DATA_IN << 1);
               mosi_d  = CPH ? 1'b0 : DATA_IN[N_BITS-1];
`ifdef SPI_TX_MISO_CAPTURE_EN
               rx_d    = '0;
`endif
            end
         end
         LEAD, SHIFT: begin
            if (tick) begin
               hcnt_d  = '0;
               sck_d   = ~SCK;
               ecnt_d  = ecnt + EW'(1);
               state_d = (ecnt == E_LAST) ? TAIL : SHIFT;
               if (sample) begin
`ifdef SPI_TX_MISO_CAPTURE_EN
                  rx_d = {rx_sh[N_BITS-2:0], MISO};
`endif
               end else if (ecnt != E_LAST) begin
                  mosi_d = tx_sh[N_BITS-1];
                  tx_d   = tx_sh << 1;
               end
            end else begin
               hcnt_d = hcnt + HW'(1);
            end
         end
         TAIL: begin
            if (tick) begin
               state_d = IDLE;
               ss_d    = 1'b1;
               mosi_d  = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               hcnt_d  = '0;
`ifdef SPI_TX_MISO_CAPTURE_EN
               dout_d  = rx_sh;
`endif
            end else begin
               hcnt_d = hcnt + HW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef SPI_TX_MISO_CAPTURE_EN
   assign DATA_OUT = dout_q;
`else
   logic unused_miso;
   assign unused_miso = MISO;
   assign DATA_OUT    = '0;
`endif

endmodule
